// File: rtl/soc_pkg.sv
// Shared SOC bus types plus the state encoding used by the bus down-sizer.
package soc_pkg;

    localparam int SOC_DATAW = 32;
    localparam int SOC_ADDRW = 32;
    localparam int SOC_BYTES = SOC_DATAW / 8;

    typedef logic [SOC_ADDRW-1:0] soc_addr_t;
    typedef logic [SOC_BYTES-1:0] soc_we_t;
    typedef logic [SOC_DATAW-1:0] soc_data_t;

    typedef enum logic [1:0] {
        DNS_IDLE   = 2'd0,
        DNS_ISSUE  = 2'd1,
        DNS_RDWAIT = 2'd2,
        DNS_RESP   = 2'd3
    } dns_state_e;

endpackage

// File: rtl/soc_lane_find.sv
// Priority search for the lowest SOC lane with any byte enable set, at or
// above (incl=1) or strictly above (incl=0) the lane index 'from'.
module soc_lane_find
    import soc_pkg::*;
#(
    parameter int RATIO = 4,
    parameter int LANEW = 2
) (
    input  logic [RATIO*SOC_BYTES-1:0] we,
    input  logic [LANEW-1:0]           from,
    input  logic                       incl,
    output logic                       found,
    output logic [LANEW-1:0]           idx
);

    // Scan from the top lane down so the lowest qualifying lane wins.
    always_comb begin : lane_scan
        logic hit_s;
        hit_s = 1'b0;
        found = 1'b0;
        idx   = '0;
        for (int i = RATIO - 1; i >= 0; i--) begin
            hit_s = (|we[i*SOC_BYTES +: SOC_BYTES]) &&
                    ((i > int'(from)) || (incl && (i == int'(from))));
            found = found | hit_s;
            idx   = hit_s ? LANEW'(i) : idx;
        end
    end

endmodule

// File: rtl/soc_bus_dnsizer.sv
// Splits one wide upstream request into RATIO narrow SOC beats (lowest lane
// first), gathers read lanes back into a wide word and signals completion.
// An all-zero byte-enable request is a read.
module soc_bus_dnsizer
    import soc_pkg::*;
#(
    parameter int MST_DATAW  = 128,
    parameter int SKIP_EMPTY = 1
) (
    input  logic                                   clk,
    input  logic                                   srst_n,
    input  logic                                   req_vld,
    output logic                                   req_rdy,
    input  logic [SOC_ADDRW-$clog2(MST_DATAW/8)-1:0] req_addr,
    input  logic [MST_DATAW/8-1:0]                 req_we,
    input  logic [MST_DATAW-1:0]                   req_wdat,
    output logic                                   rsp_vld,
    output logic [MST_DATAW-1:0]                   rsp_rdat,
    output logic                                   soc_vld,
    input  logic                                   soc_rdy,
    output soc_addr_t                              soc_addr,
    output soc_we_t                                soc_we,
    output soc_data_t                              soc_wdat,
    input  soc_data_t                              soc_rdat,
    input  logic                                   soc_rvld
);

    localparam int MST_BYTES = MST_DATAW / 8;
    localparam int RATIO     = MST_DATAW / SOC_DATAW;
    localparam int LANEW     = $clog2(RATIO);
    localparam int REQ_AW    = SOC_ADDRW - $clog2(MST_BYTES);
    localparam logic [LANEW-1:0] LAST_LANE = LANEW'(RATIO - 1);

    dns_state_e              state_q, state_d;
    logic [LANEW-1:0]        k_q, k_d;
    logic [REQ_AW-1:0]       addr_q, addr_d;
    logic [MST_BYTES-1:0]    we_q, we_d;
    logic [MST_DATAW-1:0]    wdat_q, wdat_d;
    logic [MST_DATAW-1:0]    rdat_q, rdat_d;
    logic                    soc_vld_q, soc_vld_d;
    soc_addr_t               soc_addr_q, soc_addr_d;
    soc_we_t                 soc_we_q, soc_we_d;
    soc_data_t               soc_wdat_q, soc_wdat_d;
    logic                    rsp_vld_q, rsp_vld_d;
    logic                    req_rdy_q, req_rdy_d;

    logic [MST_BYTES-1:0]    find_we;
    logic [LANEW-1:0]        find_from;
    logic                    find_incl;
    logic                    find_found;
    logic [LANEW-1:0]        find_idx;

    // In IDLE search the incoming request from lane 0; otherwise search the
    // captured enables for the next lane above the current beat.
    assign find_we   = (state_q == DNS_IDLE) ? req_we : we_q;
    assign find_from = (state_q == DNS_IDLE) ? '0 : k_q;
    assign find_incl = (state_q == DNS_IDLE);

    soc_lane_find #(
        .RATIO (RATIO),
        .LANEW (LANEW)
    ) u_lane_find (
        .we    (find_we),
        .from  (find_from),
        .incl  (find_incl),
        .found (find_found),
        .idx   (find_idx)
    );

    // Next-state, beat index and capture logic; outputs derive from next state.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        case (state_q)
            DNS_IDLE: begin
                if (req_vld && req_rdy_q) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    wdat_d  = req_wdat;
                    state_d = DNS_ISSUE;
                    if ((req_we != '0) && (SKIP_EMPTY != 0)) begin
                        k_d = find_idx;
                    end else begin
                        k_d = '0;
                    end
                end else begin
                    state_d = DNS_IDLE;
                end
            end
            DNS_ISSUE: begin
                if (soc_rdy) begin
                    if (we_q == '0) begin
                        state_d = DNS_RDWAIT;
                    end else if (SKIP_EMPTY != 0) begin
                        if (find_found) begin
                            k_d = find_idx;
                        end else begin
                            state_d = DNS_RESP;
                        end
                    end else if (k_q == LAST_LANE) begin
                        state_d = DNS_RESP;
                    end else begin
                        k_d = k_q + LANEW'(1'b1);
                    end
                end else begin
                    state_d = DNS_ISSUE;
                end
            end
            DNS_RDWAIT: begin
                if (soc_rvld) begin
                    rdat_d[int'(k_q)*SOC_DATAW +: SOC_DATAW] = soc_rdat;
                    if (k_q == LAST_LANE) begin
                        state_d = DNS_RESP;
                    end else begin
                        k_d     = k_q + LANEW'(1'b1);
                        state_d = DNS_ISSUE;
                    end
                end else begin
                    state_d = DNS_RDWAIT;
                end
            end
            DNS_RESP: begin
                state_d = DNS_IDLE;
                k_d     = '0;
            end
            default: begin
                state_d = DNS_IDLE;
                k_d     = '0;
            end
        endcase

        soc_vld_d  = (state_d == DNS_ISSUE);
        soc_addr_d = soc_addr_t'({addr_d, k_d});
        soc_we_d   = soc_vld_d ? we_d[int'(k_d)*SOC_BYTES +: SOC_BYTES] : '0;
        soc_wdat_d = soc_vld_d ? wdat_d[int'(k_d)*SOC_DATAW +: SOC_DATAW] : '0;
        rsp_vld_d  = (state_d == DNS_RESP);
        req_rdy_d  = (state_d == DNS_IDLE);
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state_q    <= DNS_IDLE;
            k_q        <= '0;
            addr_q     <= '0;
            we_q       <= '0;
            wdat_q     <= '0;
            rdat_q     <= '0;
            soc_vld_q  <= 1'b0;
            soc_addr_q <= '0;
            soc_we_q   <= '0;
            soc_wdat_q <= '0;
            rsp_vld_q  <= 1'b0;
            req_rdy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdat_q     <= wdat_d;
            rdat_q     <= rdat_d;
            soc_vld_q  <= soc_vld_d;
            soc_addr_q <= soc_addr_d;
            soc_we_q   <= soc_we_d;
            soc_wdat_q <= soc_wdat_d;
            rsp_vld_q  <= rsp_vld_d;
            req_rdy_q  <= req_rdy_d;
        end
    end

    assign req_rdy  = req_rdy_q;
    assign rsp_vld  = rsp_vld_q;
    assign rsp_rdat = rdat_q;
    assign soc_vld  = soc_vld_q;
    assign soc_addr = soc_addr_q;
    assign soc_we   = soc_we_q;
    assign soc_wdat = soc_wdat_q;

endmodule

// File: tb/tb_soc_bus_dnsizer.sv
// Directed, table-driven bench for soc_bus_dnsizer: one instance with empty
// write beats skipped and one that issues every lane.
module tb_soc_bus_dnsizer;
    import soc_pkg::*;

    localparam int AW = SOC_ADDRW - 4;

    logic clk = 1'b0;
    logic srst_n, req_vld, sel, soc_rdy, soc_rvld;
    logic [AW-1:0]  req_addr;
    logic [15:0]    req_we;
    logic [127:0]   req_wdat;
    soc_data_t      soc_rdat;

    logic req_rdy_a, req_rdy_b, rsp_vld_a, rsp_vld_b, soc_vld_a, soc_vld_b;
    logic [127:0] rsp_rdat_a, rsp_rdat_b;
    soc_addr_t soc_addr_a, soc_addr_b;
    soc_we_t   soc_we_a, soc_we_b;
    soc_data_t soc_wdat_a, soc_wdat_b;

    logic req_rdy, rsp_vld, soc_vld;
    logic [127:0] rsp_rdat;
    soc_addr_t soc_addr;
    soc_we_t   soc_we;
    soc_data_t soc_wdat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign req_rdy  = sel ? req_rdy_b  : req_rdy_a;
    assign rsp_vld  = sel ? rsp_vld_b  : rsp_vld_a;
    assign rsp_rdat = sel ? rsp_rdat_b : rsp_rdat_a;
    assign soc_vld  = sel ? soc_vld_b  : soc_vld_a;
    assign soc_addr = sel ? soc_addr_b : soc_addr_a;
    assign soc_we   = sel ? soc_we_b   : soc_we_a;
    assign soc_wdat = sel ? soc_wdat_b : soc_wdat_a;

    soc_bus_dnsizer #(.MST_DATAW(128), .SKIP_EMPTY(1)) u_dut (
        .clk(clk), .srst_n(srst_n), .req_vld(req_vld & ~sel), .req_rdy(req_rdy_a),
        .req_addr(req_addr), .req_we(req_we), .req_wdat(req_wdat),
        .rsp_vld(rsp_vld_a), .rsp_rdat(rsp_rdat_a), .soc_vld(soc_vld_a),
        .soc_rdy(soc_rdy), .soc_addr(soc_addr_a), .soc_we(soc_we_a),
        .soc_wdat(soc_wdat_a), .soc_rdat(soc_rdat), .soc_rvld(soc_rvld)
    );

    soc_bus_dnsizer #(.MST_DATAW(128), .SKIP_EMPTY(0)) u_dut_ns (
        .clk(clk), .srst_n(srst_n), .req_vld(req_vld & sel), .req_rdy(req_rdy_b),
        .req_addr(req_addr), .req_we(req_we), .req_wdat(req_wdat),
        .rsp_vld(rsp_vld_b), .rsp_rdat(rsp_rdat_b), .soc_vld(soc_vld_b),
        .soc_rdy(soc_rdy), .soc_addr(soc_addr_b), .soc_we(soc_we_b),
        .soc_wdat(soc_wdat_b), .soc_rdat(soc_rdat), .soc_rvld(soc_rvld)
    );

    typedef struct {
        logic           sel;
        logic [AW-1:0]  addr;
        logic [15:0]    we;
        logic [127:0]   wdat;
        logic [31:0]    rbase;
        logic [3:0]     mask;
        int             stall;
        int             lat;
        logic [127:0]   rdat;
    } vec_t;

    localparam logic [127:0] WD  = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;
    localparam logic [127:0] R0  = 128'h000000A3_000000A2_000000A1_000000A0;
    localparam logic [127:0] R5  = 128'h12345673_12345672_12345671_12345670;
    localparam logic [127:0] R7  = 128'h000000B3_000000B2_000000B1_000000B0;
    localparam logic [127:0] R8  = 128'h000000C3_000000C2_000000C1_000000C0;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_ctl"}, {req_rdy, rsp_vld, soc_vld, soc_we, soc_addr, soc_wdat}, '0);
        chk({name, "_rdat"}, rsp_rdat, '0);
    endtask

    // Apply one request at a negedge and follow it to completion. abort_beat >= 0
    // resets the block while it waits for the read data of that beat.
    task automatic run_txn(input string name, input vec_t v, input int abort_beat);
        int cnt, beats, last_k, k, stall_left, busy_err, arm_k, lat, bad;
        logic arm, done;
        soc_addr_t sv_addr;
        soc_we_t   sv_we;
        soc_data_t sv_wdat;
        beats = 0; last_k = -1; stall_left = 3; busy_err = 0; arm = 1'b0;
        arm_k = 0; lat = -1; done = 1'b0;
        sel = v.sel; req_addr = v.addr; req_we = v.we; req_wdat = v.wdat;
        soc_rdy = 1'b1; soc_rvld = 1'b0;
        #1;
        chk({name, "_req_rdy_idle"}, req_rdy, 1'b1);
        req_vld = 1'b1;
        @(posedge clk);
        for (cnt = 1; cnt <= 60 && !done; cnt++) begin
            @(negedge clk);
            req_vld = 1'b0;
            if (arm && abort_beat == arm_k) begin
                soc_rvld = 1'b0;
                srst_n = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk_reset_outputs({name, "_abort_reset"});
                srst_n = 1'b1;
                soc_rvld = 1'b1;
                soc_rdat = 32'hBAD0_BAD0;
                @(negedge clk);
                soc_rvld = 1'b0;
                chk({name, "_req_rdy_after_reset"}, req_rdy, 1'b1);
                bad = 0;
                for (int i = 0; i < 4; i++) begin
                    if (rsp_vld || soc_vld) bad++;
                    @(negedge clk);
                end
                chk({name, "_no_rsp_after_abort"}, 128'(bad), 128'd0);
                chk({name, "_rdat_after_abort"}, rsp_rdat, '0);
                return;
            end
            soc_rvld = arm;
            soc_rdat = arm ? (v.rbase + 32'(arm_k)) : 32'hDEAD_BEEF;
            arm = 1'b0;
            if (rsp_vld) begin
                done = 1'b1;
                lat = cnt;
            end else begin
                if (req_rdy) busy_err++;
                if (soc_vld) begin
                    if (v.stall == beats && stall_left > 0) begin
                        if (stall_left == 3) begin
                            sv_addr = soc_addr; sv_we = soc_we; sv_wdat = soc_wdat;
                        end else begin
                            chk({name, "_stall_stable"}, {soc_addr, soc_we, soc_wdat},
                                {sv_addr, sv_we, sv_wdat});
                        end
                        stall_left--;
                        soc_rdy = 1'b0;
                    end else begin
                        soc_rdy = 1'b1;
                        k = last_k + 1;
                        while (k < 4 && !v.mask[k]) k++;
                        if (k < 4) begin
                            chk($sformatf("%s_beat%0d", name, k),
                                {soc_addr, soc_we, soc_wdat},
                                {soc_addr_t'({v.addr, 2'(k)}), v.we[k*4 +: 4], v.wdat[k*32 +: 32]});
                            last_k = k;
                        end
                        beats++;
                        if (v.we == 16'h0000) begin
                            arm = 1'b1;
                            arm_k = k;
                        end
                    end
                end
            end
        end
        soc_rvld = 1'b0;
        soc_rdy = 1'b1;
        chk({name, "_latency"}, 128'(lat), 128'(v.lat));
        chk({name, "_beats"}, 128'(beats), 128'($countones(v.mask)));
        chk({name, "_rsp_rdat"}, rsp_rdat, v.rdat);
        chk({name, "_req_rdy_busy"}, 128'(busy_err), 128'd0);
        @(negedge clk);
        chk({name, "_rsp_pulse"}, {rsp_vld, req_rdy}, 2'b01);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //          sel   addr        we        wdat  rbase          mask     stall lat rdat
        vecs[0] = '{1'b0, 28'h10,      16'h0000, WD, 32'h000000A0, 4'b1111, -1,  9,  R0};
        vecs[1] = '{1'b0, 28'h20,      16'h0F00, WD, 32'h0,        4'b0100, -1,  2,  R0};
        vecs[2] = '{1'b0, 28'h21,      16'hF00F, WD, 32'h0,        4'b1001, -1,  3,  R0};
        vecs[3] = '{1'b0, 28'h22,      16'hFFFF, WD, 32'h0,        4'b1111,  1,  8,  R0};
        vecs[4] = '{1'b0, 28'h23,      16'h8000, WD, 32'h0,        4'b1000, -1,  2,  R0};
        vecs[5] = '{1'b0, 28'hFFFFFFF, 16'h0000, WD, 32'h12345670, 4'b1111, -1,  9,  R5};
        vecs[6] = '{1'b1, 28'h30,      16'h0F00, WD, 32'h0,        4'b1111, -1,  5,  128'h0};
        vecs[7] = '{1'b1, 28'h3,       16'h0000, WD, 32'h000000B0, 4'b1111, -1,  9,  R7};
        vecs[8] = '{1'b0, 28'h5,       16'h0000, WD, 32'h000000C0, 4'b1111,  1, 12,  R8};

        srst_n = 1'b0; req_vld = 1'b0; sel = 1'b0; soc_rdy = 1'b1; soc_rvld = 1'b0;
        req_addr = '0; req_we = '0; req_wdat = '0; soc_rdat = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        srst_n = 1'b1;
        @(negedge clk);
        chk("req_rdy_after_release", req_rdy, 1'b1);

        for (int i = 0; i < 9; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i], -1);
        end

        // Stray read data while idle must not touch the held read word.
        sel = 1'b0;
        soc_rvld = 1'b1;
        soc_rdat = 32'h5555_AAAA;
        @(negedge clk);
        soc_rvld = 1'b0;
        @(negedge clk);
        chk("idle_rvld_rdat", rsp_rdat, R8);
        chk("idle_rvld_rsp", {rsp_vld, soc_vld}, 2'b00);

        // Reset during the read wait of beat 2, then a clean read.
        run_txn("abort", '{1'b0, 28'h7, 16'h0000, WD, 32'h000000E0, 4'b1111, -1, 9, R0}, 2);
        run_txn("post_abort", vecs[0], -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
